serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial WIDTH-bit adder controller. It time-shares one 1-bit adder cell, built from two half-adder cells plus an OR gate, across all operand bits.
- Sequences the cell LSB-first over WIDTH cycles, using a registered carry and operand and sum shift registers.
- Sits between a requester (start/busy/done handshake) and the small single-bit adder datapath. Trades latency for area.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request pulse; sampled only when idle
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle pulse: sum/carry_out valid
- sum  output  WIDTH  registered result, a+b modulo 2^WIDTH
- carry_out  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, busy=0, done=0, sum=0, carry_out=0, internal carry=0, bit counter=0, shift registers=0. Reset has priority over every other event, including mid-RUN; a partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E: capture a and b into shift regs, clear internal carry, counter=0, go to RUN. busy=1 after edge E.
  - start=0: remain.
- RUN, each edge:
  - cell inputs are the LSB of each shift reg plus the internal carry.
  - cell sum bit shifts into the MSB of the result shift reg (right shift).
  - internal carry <= cell carry.
  - counter increments.
  - At the edge where counter == WIDTH-1 (the last bit), transfer the completed result to sum and the final cell carry to carry_out, then go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - start=1 while in DONE is accepted exactly as in IDLE: go to RUN, busy=1, done=0 next cycle. This allows back-to-back operation with no idle gap.
- Latency: start accepted at edge E gives done high during the cycle after edge E+WIDTH. busy is high during cycles E..E+WIDTH-1 (WIDTH cycles).
- Throughput: one addition per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands are not recaptured and there is no queuing.
- a and b may change freely after acceptance with no effect on the result.
- sum and carry_out update only at the final RUN edge. They hold their value through DONE, IDLE and the next RUN until the next completion; the prior result stays readable.
- done and busy are never high simultaneously.
- WIDTH=1: RUN lasts one cycle; result = a^b, carry_out = a&b.
- Counter width is clog2(WIDTH)+1 bits; it must not wrap within an operation.
- All outputs are driven directly from flops (no combinational paths from inputs).

Test Plan:
- WIDTH=8, reset 2 cycles, then start with a=3, b=5 -> busy high 8 cycles, done pulses once at cycle 9 after start; sum=8, carry_out=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1. Then a=8'hAA, b=8'h55 -> sum=8'hFF, carry_out=0. Then a=8'hFF, b=8'hFF -> sum=8'hFE, carry_out=1.
- Start a=10, b=20, then pulse start with a=100, b=100 on cycle 3 of RUN -> second request ignored; sum=30; exactly one done.
- Start a=7, b=9, change a and b on the cycle after start -> sum=16 regardless.
- Start a=200, b=100, assert rst_n=0 at cycle 4 of RUN -> busy=0, done never pulses, sum=0, carry_out=0. A new start a=1, b=1 then completes normally with sum=2.
- Hold start high continuously with a=1, b=2 -> done every 9 cycles with no idle gap; busy low only in DONE cycles; sum=3 each time.
- Exhaustive check with WIDTH=1 and WIDTH=4: all a,b pairs compared against a+b, with latency checked for each.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial adder controller.
// The requester drives start and operands; the adder returns status and result.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   modport master (
      output start, a, b,
      input  busy, done, sum, carry_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, sum, carry_out
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half adders + OR) is
// reused LSB-first over WIDTH cycles, with a start/busy/done handshake.
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   serial_adder_ctrl_if.slave bus
);
   // One extra counter bit so the count can reach WIDTH without wrapping.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [WIDTH-1:0] res_reg, res_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             carry_reg, carry_next;
   logic             co_reg, co_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   logic             ha0_s, ha0_c, ha1_s, ha1_c;
   logic             cell_s, cell_c;
   logic [WIDTH-1:0] msb_bit;

   half_adder u_ha0 (.x(a_reg[0]), .y(b_reg[0]),  .s(ha0_s), .c(ha0_c));
   half_adder u_ha1 (.x(ha0_s),    .y(carry_reg), .s(ha1_s), .c(ha1_c));

   assign cell_s = ha1_s;
   assign cell_c = ha0_c | ha1_c;

   always_comb begin
      msb_bit          = '0;
      msb_bit[WIDTH-1] = cell_s;
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      res_next   = res_reg;
      sum_next   = sum_reg;
      cnt_next   = cnt_reg;
      carry_next = carry_reg;
      co_next    = co_reg;
      case (state_reg)
         IDLE, DONE: begin
            // DONE accepts a new request exactly like IDLE for back-to-back use.
            state_next = IDLE;
            if (bus.start) begin
               a_next     = bus.a;
               b_next     = bus.b;
               res_next   = '0;
               carry_next = 1'b0;
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            a_next     = a_reg >> 1;
            b_next     = b_reg >> 1;
            res_next   = (res_reg >> 1) | msb_bit;
            carry_next = cell_c;
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
               sum_next   = (res_reg >> 1) | msb_bit;
               co_next    = cell_c;
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == RUN);
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         sum_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         co_reg    <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         res_reg   <= res_next;
         sum_reg   <= sum_next;
         cnt_reg   <= cnt_next;
         carry_reg <= carry_next;
         co_reg    <= co_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.sum       = sum_reg;
   assign bus.carry_out = co_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of the bit-serial adder at WIDTH 8, 4 and 1
// against plain-arithmetic expectations for result, carry and timing.
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
   serial_adder_ctrl_if #(.WIDTH(4)) if4 ();
   serial_adder_ctrl_if #(.WIDTH(1)) if1 ();

   serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_adder_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv);
      case (w)
         8:       begin if8.start = s; if8.a = av;      if8.b = bv;      end
         4:       begin if4.start = s; if4.a = av[3:0]; if4.b = bv[3:0]; end
         default: begin if1.start = s; if1.a = av[0];   if1.b = bv[0];   end
      endcase
   endtask

   task automatic get_out(input int w, output logic bsy, output logic dn,
                          output logic [31:0] sm, output logic co);
      case (w)
         8:       begin bsy = if8.busy; dn = if8.done; sm = 32'(if8.sum); co = if8.carry_out; end
         4:       begin bsy = if4.busy; dn = if4.done; sm = 32'(if4.sum); co = if4.carry_out; end
         default: begin bsy = if1.busy; dn = if1.done; sm = 32'(if1.sum); co = if1.carry_out; end
      endcase
   endtask

   // Called at a negedge with the DUT idle. ign_at>0 pulses a competing start
   // (a=b=100) during that RUN cycle, which must be ignored.
   task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input int ign_at, input string tag);
      int          cyc, busy_cnt, overlap;
      logic [31:0] mask, full, exp_sum, exp_co, sm;
      logic        bsy, dn, co;
      mask    = (32'd1 << w) - 1;
      full    = (32'(av) & mask) + (32'(bv) & mask);
      exp_sum = full & mask;
      exp_co  = full >> w;
      set_in(w, 1'b1, av, bv);
      cyc = 0; busy_cnt = 0; overlap = 0; dn = 1'b0;
      while (!dn && cyc < 40) begin
         @(negedge clk);
         cyc++;
         get_out(w, bsy, dn, sm, co);
         if (bsy) busy_cnt++;
         if (bsy && dn) overlap++;
         if (cyc == 1) set_in(w, 1'b0, 8'($urandom), 8'($urandom));
         if (ign_at > 0 && cyc == ign_at) set_in(w, 1'b1, 8'd100, 8'd100);
         if (ign_at > 0 && cyc == ign_at + 1) set_in(w, 1'b0, 8'd100, 8'd100);
      end
      check({tag, ".latency"}, 32'(cyc), 32'(w + 1));
      check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(w));
      check({tag, ".overlap"}, 32'(overlap), 32'd0);
      check({tag, ".sum"}, sm, exp_sum);
      check({tag, ".carry"}, 32'(co), exp_co);
      $display("op %s w=%0d a=%0h b=%0h sum=%0h co=%0d latency=%0d", tag, w, av & mask[7:0],
               bv & mask[7:0], sm, co, cyc);
      @(negedge clk);
      get_out(w, bsy, dn, sm, co);
      check({tag, ".idle_after"}, {30'd0, bsy, dn}, 32'd0);
   endtask

   initial begin
      logic        bsy, dn, co;
      logic [31:0] sm;
      int          dn_cnt;
      rst_n = 1'b0;
      set_in(8, 1'b0, 8'd0, 8'd0);
      set_in(4, 1'b0, 8'd0, 8'd0);
      set_in(1, 1'b0, 8'd0, 8'd0);
      repeat (2) @(negedge clk);
      get_out(8, bsy, dn, sm, co);
      check("reset.busy", 32'(bsy), 32'd0);
      check("reset.done", 32'(dn), 32'd0);
      check("reset.sum", sm, 32'd0);
      check("reset.carry", 32'(co), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8, 8'd3,   8'd5,   0, "add_3_5");
      run_op(8, 8'hFF, 8'h01,  0, "ff_01");
      run_op(8, 8'hAA, 8'h55,  0, "aa_55");
      run_op(8, 8'hFF, 8'hFF,  0, "ff_ff");
      run_op(8, 8'd10, 8'd20,  3, "ignore_start");
      run_op(8, 8'd7,  8'd9,   0, "operand_change");

      // Reset in the middle of a RUN discards the work and clears the result.
      set_in(8, 1'b1, 8'd200, 8'd100);
      @(negedge clk);
      set_in(8, 1'b0, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      get_out(8, bsy, dn, sm, co);
      check("midreset.busy", 32'(bsy), 32'd0);
      check("midreset.sum", sm, 32'd0);
      check("midreset.carry", 32'(co), 32'd0);
      rst_n  = 1'b1;
      dn_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         get_out(8, bsy, dn, sm, co);
         if (dn || bsy) dn_cnt++;
      end
      check("midreset.no_done", 32'(dn_cnt), 32'd0);
      $display("op midreset w=8 a=c8 b=64 aborted");
      run_op(8, 8'd1, 8'd1, 0, "after_reset");

      // Continuous start: one result every WIDTH+1 cycles, no idle gap.
      set_in(8, 1'b1, 8'd1, 8'd2);
      for (int k = 1; k <= 27; k++) begin
         @(negedge clk);
         get_out(8, bsy, dn, sm, co);
         check("b2b.done", 32'(dn), 32'(k % 9 == 0));
         check("b2b.busy", 32'(bsy), 32'(k % 9 != 0));
         if (k % 9 == 0) begin
            check("b2b.sum", sm, 32'd3);
            $display("op b2b w=8 a=1 b=2 sum=%0h co=%0d at_cycle=%0d", sm, co, k);
         end
      end
      set_in(8, 1'b0, 8'd0, 8'd0);
      @(negedge clk);

      for (int i = 0; i < 20; i++)
         run_op(8, 8'($urandom), 8'($urandom), 0, "rand8");

      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            run_op(4, 8'(x), 8'(y), 0, "exh4");

      for (int x = 0; x < 2; x++)
         for (int y = 0; y < 2; y++)
            run_op(1, 8'(x), 8'(y), 0, "exh1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
